// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the scoreboard controller.
//   sb_state_e : controller mode (normal compare vs. end-of-test drain)
//   CNT_BITS   : width of the statistics counters
//   sat_inc    : saturating increment used by every statistics counter
package scoreboard_pkg;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } sb_state_e;

    localparam int CNT_BITS = 32;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/scoreboard_rr_arb.sv
// Round-robin arbiter for the expected-sample requesters.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          request vector, one bit per requester
//   en           allows a grant this cycle (state/full gating done by caller)
//   grant        one-hot grant vector
//   grant_idx    index of the granted requester
//   grant_valid  a grant is issued this cycle
// The search starts at the registered pointer and wraps. The pointer moves
// to one past the winner only when a grant is actually issued.
module scoreboard_rr_arb #(
    parameter  int REQS = 4,
    localparam int TAGW = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REQS-1:0] req,
    input  logic            en,
    output logic [REQS-1:0] grant,
    output logic [TAGW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [TAGW-1:0] ptr_reg;
    logic [TAGW-1:0] ptr_next;
    logic [TAGW-1:0] cand_idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < REQS; k++) begin
            cand_idx = TAGW'((int'(ptr_reg) + k) % REQS);
            if (en && !grant_valid && req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < REQS; gi++) begin : g_grant
            assign grant[gi] = grant_valid && (grant_idx == TAGW'(gi));
        end
    endgenerate

    // Explicit wrap keeps non-power-of-two REQS inside range.
    assign ptr_next = (grant_idx == TAGW'(REQS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (grant_valid) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Scoreboard controller: arbitrates expected samples from REQS monitors into
// an external scoreboard FIFO (tagged {requester, data}), pops and compares on
// each actual sample, and keeps match/mismatch/orphan statistics plus sticky
// underflow and timeout errors. A flush pulse drains the FIFO.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_data/req_ready    expected-sample requesters (REQS lanes)
//   act_valid/act_tag/act_data      actual sample (no backpressure)
//   flush                           start draining the FIFO
//   fifo_enq/fifo_wdata/fifo_deq    FIFO write/pop controls
//   fifo_rdata/fifo_full/fifo_empty FIFO head and status
//   match_cnt/mismatch_cnt/orphan_cnt   saturating statistics
//   mismatch                        registered pulse after a failing compare
//   underflow_err/timeout_err       sticky errors
//   flush_done                      registered pulse as RUN resumes after a drain
module scoreboard_ctrl
    import scoreboard_pkg::*;
#(
    parameter  int REQS    = 4,
    parameter  int BITS    = 24,
    parameter  int TIMEOUT = 1000,
    localparam int TAGW    = $clog2(REQS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQS-1:0]      req_valid,
    input  logic [REQS*BITS-1:0] req_data,
    output logic [REQS-1:0]      req_ready,
    input  logic                 act_valid,
    input  logic [TAGW-1:0]      act_tag,
    input  logic [BITS-1:0]      act_data,
    input  logic                 flush,
    output logic                 fifo_enq,
    output logic [TAGW+BITS-1:0] fifo_wdata,
    output logic                 fifo_deq,
    input  logic [TAGW+BITS-1:0] fifo_rdata,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic [CNT_BITS-1:0]  match_cnt,
    output logic [CNT_BITS-1:0]  mismatch_cnt,
    output logic [CNT_BITS-1:0]  orphan_cnt,
    output logic                 mismatch,
    output logic                 underflow_err,
    output logic                 timeout_err,
    output logic                 flush_done
);

    localparam int TMOW = $clog2(TIMEOUT + 1);

    sb_state_e        state_reg;
    logic [TMOW-1:0]  tmo_cnt_reg;
    logic             run;
    logic             arb_en;
    logic [TAGW-1:0]  grant_idx;
    logic             grant_valid;
    logic             cmp_fire;
    logic             cmp_hit;
    logic [BITS-1:0]  req_data_arr [REQS];

    genvar gi;
    generate
        for (gi = 0; gi < REQS; gi++) begin : g_unpack
            assign req_data_arr[gi] = req_data[gi*BITS +: BITS];
        end
    endgenerate

    assign run = (state_reg == SB_RUN);

    // No new entry is accepted in the cycle a flush is requested, so the
    // drain covers exactly what was queued when flush arrived.
    assign arb_en = run && !fifo_full && !flush;

    scoreboard_rr_arb #(
        .REQS (REQS)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .en          (arb_en),
        .grant       (req_ready),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign fifo_enq   = grant_valid;
    assign fifo_wdata = {grant_idx, req_data_arr[grant_idx]};

    assign cmp_fire = run && act_valid && !fifo_empty;
    assign cmp_hit  = ({act_tag, act_data} == fifo_rdata);
    // In FLUSH every non-empty cycle pops one entry.
    assign fifo_deq = cmp_fire || (!run && !fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SB_RUN;
            tmo_cnt_reg   <= '0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            orphan_cnt    <= '0;
            mismatch      <= 1'b0;
            underflow_err <= 1'b0;
            timeout_err   <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            mismatch   <= 1'b0;
            flush_done <= 1'b0;
            case (state_reg)
                SB_RUN: begin
                    if (flush) begin
                        state_reg <= SB_FLUSH;
                    end
                    if (cmp_fire) begin
                        if (cmp_hit) begin
                            match_cnt <= sat_inc(match_cnt);
                        end else begin
                            mismatch_cnt <= sat_inc(mismatch_cnt);
                            mismatch     <= 1'b1;
                        end
                    end
                    if (act_valid && fifo_empty) begin
                        underflow_err <= 1'b1;
                    end
                    // Count idle cycles with data waiting; the error fires on
                    // the edge where the count reaches TIMEOUT, then it holds.
                    if (!fifo_empty && !act_valid) begin
                        if (tmo_cnt_reg != TMOW'(TIMEOUT)) begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                        if (tmo_cnt_reg >= TMOW'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_reg <= '0;
                    end
                end
                SB_FLUSH: begin
                    tmo_cnt_reg <= '0;
                    if (fifo_empty) begin
                        state_reg  <= SB_RUN;
                        flush_done <= 1'b1;
                    end else begin
                        orphan_cnt <= sat_inc(orphan_cnt);
                    end
                end
                default: state_reg <= SB_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl with a 4-entry FIFO built in.
module tb_scoreboard_ctrl;

    localparam int REQS    = 4;
    localparam int BITS    = 24;
    localparam int TIMEOUT = 16;
    localparam int TAGW    = 2;
    localparam int W       = TAGW + BITS;

    logic                 clk;
    logic                 rst_n;
    logic [REQS-1:0]      req_valid;
    logic [REQS*BITS-1:0] req_data;
    logic [REQS-1:0]      req_ready;
    logic                 act_valid;
    logic [TAGW-1:0]      act_tag;
    logic [BITS-1:0]      act_data;
    logic                 flush;
    logic                 fifo_enq;
    logic [W-1:0]         fifo_wdata;
    logic                 fifo_deq;
    logic [W-1:0]         fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [31:0]          match_cnt;
    logic [31:0]          mismatch_cnt;
    logic [31:0]          orphan_cnt;
    logic                 mismatch;
    logic                 underflow_err;
    logic                 timeout_err;
    logic                 flush_done;

    int tests;
    int fails;

    scoreboard_ctrl #(
        .REQS    (REQS),
        .BITS    (BITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .act_valid     (act_valid),
        .act_tag       (act_tag),
        .act_data      (act_data),
        .flush         (flush),
        .fifo_enq      (fifo_enq),
        .fifo_wdata    (fifo_wdata),
        .fifo_deq      (fifo_deq),
        .fifo_rdata    (fifo_rdata),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .match_cnt     (match_cnt),
        .mismatch_cnt  (mismatch_cnt),
        .orphan_cnt    (orphan_cnt),
        .mismatch      (mismatch),
        .underflow_err (underflow_err),
        .timeout_err   (timeout_err),
        .flush_done    (flush_done)
    );

    // 4-entry scoreboard FIFO sharing the controller's reset.
    logic [W-1:0] fifo_mem [4];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic [2:0]   fifo_count;
    logic         enq_ok;
    logic         deq_ok;

    assign fifo_full  = (fifo_count == 3'd4);
    assign fifo_empty = (fifo_count == 3'd0);
    assign fifo_rdata = fifo_mem[rd_ptr];
    assign enq_ok     = fifo_enq && !fifo_full;
    assign deq_ok     = fifo_deq && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (enq_ok) begin
                fifo_mem[wr_ptr] <= fifo_wdata;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (deq_ok) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_count <= fifo_count + {2'b00, enq_ok} - {2'b00, deq_ok};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        act_valid = 1'b0;
        act_tag   = '0;
        act_data  = '0;
        flush     = 1'b0;
        tick();
        tick();
        #1;
        if ({match_cnt, mismatch_cnt, orphan_cnt} !== 96'd0) begin
            $display("FAIL reset_counters: got %h/%h/%h required 0/0/0", match_cnt, mismatch_cnt, orphan_cnt);
            fails++;
        end
        tests++;
        if ({mismatch, underflow_err, timeout_err, flush_done} !== 4'b0) begin
            $display("FAIL reset_flags: got %b required 0000", {mismatch, underflow_err, timeout_err, flush_done});
            fails++;
        end
        tests++;
        if ({req_ready, fifo_enq, fifo_deq} !== 6'b0) begin
            $display("FAIL reset_handshake: got %b required 000000", {req_ready, fifo_enq, fifo_deq});
            fails++;
        end
        tests++;
        tick();
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_round_robin();
        logic [TAGW-1:0] t;
        tick();
        req_valid = 4'hF;
        for (int i = 0; i < REQS; i++) req_data[i*BITS +: BITS] = 24'h10 + 24'(i);
        for (int k = 0; k < REQS; k++) begin
            if (k > 0) tick();
            #1;
            $display("[TB] rr cycle %0d ready=%b wdata=%h", k, req_ready, fifo_wdata);
            if (req_ready !== (4'b0001 << k) || fifo_enq !== 1'b1) begin
                $display("FAIL rr_grant%0d: got ready=%b enq=%b required ready=%b enq=1", k, req_ready, fifo_enq, 4'b0001 << k);
                fails++;
            end
            tests++;
            if (fifo_wdata !== {2'(k), 24'h10 + 24'(k)}) begin
                $display("FAIL rr_wdata%0d: got %h required %h", k, fifo_wdata, {2'(k), 24'h10 + 24'(k)});
                fails++;
            end
            tests++;
        end
        // FIFO now full: no grant even though everyone is still requesting.
        tick();
        #1;
        if (req_ready !== 4'b0 || fifo_enq !== 1'b0 || fifo_full !== 1'b1) begin
            $display("FAIL rr_full_block: got ready=%b enq=%b full=%b required 0000/0/1", req_ready, fifo_enq, fifo_full);
            fails++;
        end
        tests++;
        // Pop the head while still full: deq allowed, enq still blocked.
        act_valid = 1'b1;
        act_tag   = 2'd0;
        act_data  = 24'h10;
        #1;
        if (fifo_deq !== 1'b1 || req_ready !== 4'b0) begin
            $display("FAIL rr_full_deq: got deq=%b ready=%b required 1/0000", fifo_deq, req_ready);
            fails++;
        end
        tests++;
        tick();
        act_valid = 1'b0;
        #1;
        // Pointer held at 0 through the blocked cycle.
        if (req_ready !== 4'b0001 || match_cnt !== 32'd1) begin
            $display("FAIL rr_ptr_held: got ready=%b match=%0d required 0001/1", req_ready, match_cnt);
            fails++;
        end
        tests++;
        tick();
        req_valid = '0;
        // Queue holds requesters 1,2,3,0 in that order.
        for (int k = 0; k < REQS; k++) begin
            if (k > 0) tick();
            t         = 2'(k + 1);
            act_valid = 1'b1;
            act_tag   = t;
            act_data  = 24'h10 + {22'd0, t};
            #1;
            $display("[TB] act tag=%0d data=%h head=%h", act_tag, act_data, fifo_rdata);
            if (fifo_deq !== 1'b1) begin
                $display("FAIL rr_drain_deq%0d: got %b required 1", k, fifo_deq);
                fails++;
            end
            tests++;
        end
        tick();
        act_valid = 1'b0;
        #1;
        if (match_cnt !== 32'd5 || mismatch_cnt !== 32'd0 || fifo_empty !== 1'b1) begin
            $display("FAIL rr_drain_result: got match=%0d mismatch=%0d empty=%b required 5/0/1", match_cnt, mismatch_cnt, fifo_empty);
            fails++;
        end
        tests++;
    endtask

    task automatic test_compare();
        tick();
        req_valid = 4'b0010;
        req_data[1*BITS +: BITS] = 24'hABCDEF;
        #1;
        if (req_ready !== 4'b0010 || fifo_wdata !== {2'd1, 24'hABCDEF}) begin
            $display("FAIL cmp_push1: got ready=%b wdata=%h required 0010/%h", req_ready, fifo_wdata, {2'd1, 24'hABCDEF});
            fails++;
        end
        tests++;
        tick();
        req_valid = '0;
        act_valid = 1'b1;
        act_tag   = 2'd1;
        act_data  = 24'hABCDEF;
        $display("[TB] act tag=1 data=abcdef");
        tick();
        act_valid = 1'b0;
        req_valid = 4'b0100;
        req_data[2*BITS +: BITS] = 24'h5;
        #1;
        if (match_cnt !== 32'd6 || mismatch !== 1'b0) begin
            $display("FAIL cmp_match: got match=%0d mismatch=%b required 6/0", match_cnt, mismatch);
            fails++;
        end
        tests++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL cmp_push2: got ready=%b required 0100", req_ready);
            fails++;
        end
        tests++;
        tick();
        req_valid = '0;
        act_valid = 1'b1;
        act_tag   = 2'd2;
        act_data  = 24'h6;
        $display("[TB] act tag=2 data=000006");
        tick();
        act_valid = 1'b0;
        #1;
        if (mismatch !== 1'b1 || mismatch_cnt !== 32'd1 || match_cnt !== 32'd6 || fifo_empty !== 1'b1) begin
            $display("FAIL cmp_mismatch: got pulse=%b mismatch=%0d match=%0d empty=%b required 1/1/6/1", mismatch, mismatch_cnt, match_cnt, fifo_empty);
            fails++;
        end
        tests++;
        tick();
        #1;
        if (mismatch !== 1'b0) begin
            $display("FAIL cmp_pulse_width: got %b required 0", mismatch);
            fails++;
        end
        tests++;
    endtask

    task automatic test_underflow();
        tick();
        act_valid = 1'b1;
        act_tag   = 2'd0;
        act_data  = 24'h0;
        #1;
        $display("[TB] act on empty fifo");
        if (fifo_deq !== 1'b0) begin
            $display("FAIL uf_no_deq: got %b required 0", fifo_deq);
            fails++;
        end
        tests++;
        tick();
        act_valid = 1'b0;
        #1;
        if (underflow_err !== 1'b1 || match_cnt !== 32'd6 || mismatch_cnt !== 32'd1 || mismatch !== 1'b0) begin
            $display("FAIL uf_flag: got err=%b match=%0d mismatch=%0d pulse=%b required 1/6/1/0", underflow_err, match_cnt, mismatch_cnt, mismatch);
            fails++;
        end
        tests++;
    endtask

    task automatic test_timeout();
        tick();
        req_valid = 4'b0001;
        req_data[0 +: BITS] = 24'h77;
        #1;
        if (req_ready !== 4'b0001 || timeout_err !== 1'b0) begin
            $display("FAIL tmo_push: got ready=%b err=%b required 0001/0", req_ready, timeout_err);
            fails++;
        end
        tests++;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            req_valid = '0;
        end
        #1;
        // Fifteen idle cycles counted so far.
        if (timeout_err !== 1'b0) begin
            $display("FAIL tmo_early: got %b required 0", timeout_err);
            fails++;
        end
        tests++;
        tick();
        act_valid = 1'b1;
        act_tag   = 2'd0;
        act_data  = 24'h77;
        #1;
        if (timeout_err !== 1'b1) begin
            $display("FAIL tmo_fire: got %b required 1", timeout_err);
            fails++;
        end
        tests++;
        tick();
        act_valid = 1'b0;
        #1;
        if (timeout_err !== 1'b1 || match_cnt !== 32'd7) begin
            $display("FAIL tmo_sticky: got err=%b match=%0d required 1/7", timeout_err, match_cnt);
            fails++;
        end
        tests++;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            tick();
            req_valid = 4'b0001;
            req_data[0 +: BITS] = 24'h20 + 24'(k);
            #1;
            if (req_ready !== 4'b0001) begin
                $display("FAIL fl_fill%0d: got %b required 0001", k, req_ready);
                fails++;
            end
            tests++;
        end
        tick();
        flush = 1'b1;
        #1;
        $display("[TB] flush requested with 3 entries");
        if (req_ready !== 4'b0 || fifo_enq !== 1'b0) begin
            $display("FAIL fl_req_cycle: got ready=%b enq=%b required 0000/0", req_ready, fifo_enq);
            fails++;
        end
        tests++;
        for (int k = 0; k < 3; k++) begin
            tick();
            flush = 1'b0;
            #1;
            if (req_ready !== 4'b0 || fifo_deq !== 1'b1) begin
                $display("FAIL fl_drain%0d: got ready=%b deq=%b required 0000/1", k, req_ready, fifo_deq);
                fails++;
            end
            tests++;
        end
        tick();
        #1;
        if (fifo_deq !== 1'b0 || req_ready !== 4'b0 || flush_done !== 1'b0 || orphan_cnt !== 32'd3) begin
            $display("FAIL fl_empty: got deq=%b ready=%b done=%b orphan=%0d required 0/0000/0/3", fifo_deq, req_ready, flush_done, orphan_cnt);
            fails++;
        end
        tests++;
        tick();
        req_data[0 +: BITS] = 24'h23;
        #1;
        if (flush_done !== 1'b1 || req_ready !== 4'b0001 || orphan_cnt !== 32'd3) begin
            $display("FAIL fl_done: got done=%b ready=%b orphan=%0d required 1/0001/3", flush_done, req_ready, orphan_cnt);
            fails++;
        end
        tests++;
        tick();
        req_data[0 +: BITS] = 24'h24;
        #1;
        if (flush_done !== 1'b0 || req_ready !== 4'b0001) begin
            $display("FAIL fl_done_once: got done=%b ready=%b required 0/0001", flush_done, req_ready);
            fails++;
        end
        tests++;
    endtask

    task automatic test_reset_mid_flush();
        tick();
        req_valid = '0;
        flush     = 1'b1;
        $display("[TB] flush requested with 2 entries");
        tick();
        flush = 1'b0;
        #1;
        if (fifo_deq !== 1'b1) begin
            $display("FAIL rst_fl_deq: got %b required 1", fifo_deq);
            fails++;
        end
        tests++;
        tick();
        #1;
        if (orphan_cnt !== 32'd4) begin
            $display("FAIL rst_fl_orphan: got %0d required 4", orphan_cnt);
            fails++;
        end
        tests++;
        rst_n = 1'b0;
        #1;
        if ({match_cnt, mismatch_cnt, orphan_cnt} !== 96'd0) begin
            $display("FAIL rst_mid_counters: got %h/%h/%h required 0/0/0", match_cnt, mismatch_cnt, orphan_cnt);
            fails++;
        end
        tests++;
        if ({mismatch, underflow_err, timeout_err, flush_done, fifo_deq, fifo_enq} !== 6'b0) begin
            $display("FAIL rst_mid_flags: got %b required 000000", {mismatch, underflow_err, timeout_err, flush_done, fifo_deq, fifo_enq});
            fails++;
        end
        tests++;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_data[0 +: BITS] = 24'h99;
        #1;
        $display("[TB] reset released after mid-flush reset");
        if (req_ready !== 4'b0001 || fifo_empty !== 1'b1 || fifo_wdata !== {2'd0, 24'h99}) begin
            $display("FAIL rst_first_grant: got ready=%b empty=%b wdata=%h required 0001/1/%h", req_ready, fifo_empty, fifo_wdata, {2'd0, 24'h99});
            fails++;
        end
        tests++;
        tick();
        req_valid = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_round_robin();
        test_compare();
        test_underflow();
        test_timeout();
        test_flush();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
